mem_stage: RTL

Memory-access pipeline stage sitting directly downstream of EX. It owns the EX/MEM pipeline register and routes each memory instruction to the Dcache (addresses below 32'h2000_0000) or the system bus (at or above it). It holds the pipeline with a stall until the target acknowledges, then aligns and extends load data. It presents a single-cycle writeback result to WB; non-memory instructions pass through with one cycle of latency.

---
 rtl/mem_stage_pkg.sv | 32 +++
 rtl/mem_lane_fmt.sv | 69 ++++++
 rtl/mem_stage.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/mem_stage_pkg.sv
// -----------------------------------------------------------------------------
// mem_stage_pkg
//   Shared definitions for the memory-access pipeline stage:
//   - access width encodings (MW_BYTE / MW_HALF / MW_WORD; 2'b11 is a word too)
//   - default Dcache / system-bus address split
//   - FSM state encoding of mem_stage
//   - misalignment helper, used only when MEM_MISALIGN_TRAP_EN is defined
// -----------------------------------------------------------------------------
package mem_stage_pkg;

  localparam logic [1:0] MW_BYTE = 2'b00;
  localparam logic [1:0] MW_HALF = 2'b01;
  localparam logic [1:0] MW_WORD = 2'b10;

  // First bus-mapped address; everything below goes to the Dcache.
  localparam logic [31:0] REGION_SPLIT_DEFAULT = 32'h2000_0000;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_DC  = 2'd1,
    ST_WAIT_BUS = 2'd2,
    ST_RESP     = 2'd3
  } mem_state_e;

  // Half needs addr[0] clear; word (2'b10 or 2'b11) needs addr[1:0] clear.
  function automatic logic is_misaligned(input logic [1:0] width,
                                         input logic [1:0] addr_lo);
    return ((width == MW_HALF) && addr_lo[0]) ||
           (width[1] && (addr_lo != 2'b00));
  endfunction

endpackage

// File: rtl/mem_lane_fmt.sv
// -----------------------------------------------------------------------------
// mem_lane_fmt
//   Purely combinational byte-lane formatter.
//   Store side: replicates store data across lanes and builds byte strobes.
//   Load side : selects the addressed lane of the returned word and extends.
//   A half uses addr_lo[1] only; a word always uses the full word (lane 0),
//   so misaligned low address bits are silently ignored here.
//
// Ports
//   width      in  2   access width (MW_BYTE / MW_HALF / word)
//   rdtype     in  1   0 = sign-extend, 1 = zero-extend
//   addr_lo    in  2   low address bits
//   wr_data    in  32  store data, LSB-justified
//   rdata      in  32  raw read word from Dcache / bus
//   st_data    out 32  lane-replicated store data
//   st_strb    out 4   byte strobes
//   ld_data    out 32  aligned and extended load result
// -----------------------------------------------------------------------------
module mem_lane_fmt
  import mem_stage_pkg::*;
(
  input  logic [1:0]  width,
  input  logic        rdtype,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wr_data,
  input  logic [31:0] rdata,
  output logic [31:0] st_data,
  output logic [3:0]  st_strb,
  output logic [31:0] ld_data
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  always_comb begin
    ld_byte = rdata[7:0];
    case (addr_lo)
      2'd0:    ld_byte = rdata[7:0];
      2'd1:    ld_byte = rdata[15:8];
      2'd2:    ld_byte = rdata[23:16];
      default: ld_byte = rdata[31:24];
    endcase
    ld_half = addr_lo[1] ? rdata[31:16] : rdata[15:0];
  end

  always_comb begin
    st_data = wr_data;
    st_strb = 4'b1111;
    ld_data = rdata;
    case (width)
      MW_BYTE: begin
        st_data = {4{wr_data[7:0]}};
        st_strb = 4'b0001 << addr_lo;
        ld_data = rdtype ? {24'h0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
      end
      MW_HALF: begin
        st_data = {2{wr_data[15:0]}};
        st_strb = 4'b0011 << {addr_lo[1], 1'b0};
        ld_data = rdtype ? {16'h0, ld_half} : {{16{ld_half[15]}}, ld_half};
      end
      default: begin
        st_data = wr_data;
        st_strb = 4'b1111;
        ld_data = rdata;
      end
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// -----------------------------------------------------------------------------
// mem_stage
//   Memory-access pipeline stage downstream of EX. Owns the EX/MEM register,
//   routes memory accesses to the Dcache (addr < REGION_SPLIT) or the system
//   bus (addr >= REGION_SPLIT), stalls until the target acks, formats load
//   data and presents a single-cycle writeback result to WB. Non-memory
//   instructions pass through with one cycle of latency.
//
//   Optional build macro: MEM_MISALIGN_TRAP_EN
//     defined   : misaligned half/word accesses issue no request and produce a
//                 RESP cycle with mem_misalign_o = 1 and no register write.
//     undefined : mem_misalign_o is always 0; offending low bits are ignored.
//
// State table
//   state       | meaning
//   ST_IDLE     | nothing held (only after reset); capture on cap
//   ST_WAIT_DC  | Dcache request outstanding, pipeline stalled
//   ST_WAIT_BUS | system bus request outstanding, pipeline stalled
//   ST_RESP     | writeback result valid; capture next op on cap
//
// Ports
//   clk, rst_n                    clock, synchronous active-low reset
//   ex_*                          EX/MEM inputs (data, dest, we, mem controls)
//   fc_stall_mem_i                flow-controller freeze
//   dc_req_o / bus_req_o          request to Dcache / bus
//   mem_rw_o, mem_addr_o,
//   mem_wdata_o, mem_wstrb_o      shared request payload (0 when idle)
//   dc_ack_i/dc_rdata_i,
//   bus_ack_i/bus_rdata_i         one-cycle acks with read data
//   mem_stall_o                   stall to the flow controller
//   mem_valid_o, mem_reg_*        writeback result (all 0 when not valid)
//   mem_misalign_o                misalignment exception
// -----------------------------------------------------------------------------
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter logic [31:0] REGION_SPLIT = REGION_SPLIT_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] ex_reg_wdata_i,
  input  logic [4:0]  ex_reg_waddr_i,
  input  logic        ex_reg_we_i,
  input  logic        ex_mtype_i,
  input  logic        ex_mem_rw_i,
  input  logic [1:0]  ex_mem_width_i,
  input  logic        ex_mem_rdtype_i,
  input  logic [31:0] ex_mem_addr_i,
  input  logic [31:0] ex_mem_wr_data_i,
  input  logic        fc_stall_mem_i,
  output logic        dc_req_o,
  output logic        bus_req_o,
  output logic        mem_rw_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  output logic [3:0]  mem_wstrb_o,
  input  logic        dc_ack_i,
  input  logic        bus_ack_i,
  input  logic [31:0] dc_rdata_i,
  input  logic [31:0] bus_rdata_i,
  output logic        mem_stall_o,
  output logic        mem_valid_o,
  output logic [31:0] mem_reg_wdata_o,
  output logic [4:0]  mem_reg_waddr_o,
  output logic        mem_reg_we_o,
  output logic        mem_misalign_o
);

  mem_state_e state_q, state_d;

  logic        cap;
  logic        cap_go;
  logic        ack_hit;
  logic        misalign_in;
  logic        in_req;

  logic [31:0] r_wdata;
  logic [4:0]  r_waddr;
  logic        r_we;
  logic        r_rw;
  logic [1:0]  r_width;
  logic        r_rdtype;
  logic [31:0] r_addr;
  logic [31:0] r_wr_data;
  logic        r_misalign;

  logic [31:0] rdata_sel;
  logic [31:0] st_data;
  logic [3:0]  st_strb;
  logic [31:0] ld_data;

`ifdef MEM_MISALIGN_TRAP_EN
  assign misalign_in = ex_mtype_i && is_misaligned(ex_mem_width_i, ex_mem_addr_i[1:0]);
`else
  assign misalign_in = 1'b0;
`endif

  assign in_req      = (state_q == ST_WAIT_DC) || (state_q == ST_WAIT_BUS);
  assign mem_stall_o = in_req;
  assign cap         = !mem_stall_o && !fc_stall_mem_i;

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    cap_go  = 1'b0;
    ack_hit = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cap_go = cap;
      end
      ST_WAIT_DC: begin
        if (dc_ack_i) begin
          ack_hit = 1'b1;
          state_d = ST_RESP;
        end
      end
      ST_WAIT_BUS: begin
        if (bus_ack_i) begin
          ack_hit = 1'b1;
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        // A freeze holds the result on the writeback port.
        state_d = fc_stall_mem_i ? ST_RESP : ST_IDLE;
        cap_go  = cap;
      end
      default: state_d = ST_IDLE;
    endcase
    // Capture overrides the default transition so back-to-back ops never
    // pass through IDLE.
    if (cap_go) begin
      if (ex_mtype_i && !misalign_in)
        state_d = (ex_mem_addr_i < REGION_SPLIT) ? ST_WAIT_DC : ST_WAIT_BUS;
      else
        state_d = ST_RESP;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wdata    <= 32'h0;
      r_waddr    <= 5'h0;
      r_we       <= 1'b0;
      r_rw       <= 1'b0;
      r_width    <= MW_BYTE;
      r_rdtype   <= 1'b0;
      r_addr     <= 32'h0;
      r_wr_data  <= 32'h0;
      r_misalign <= 1'b0;
    end else if (cap_go) begin
      r_wdata    <= ex_reg_wdata_i;
      r_waddr    <= ex_reg_waddr_i;
      // Stores never write the register file.
      r_we       <= ex_reg_we_i && !(ex_mtype_i && ex_mem_rw_i);
      r_rw       <= ex_mtype_i && ex_mem_rw_i;
      r_width    <= ex_mem_width_i;
      r_rdtype   <= ex_mem_rdtype_i;
      r_addr     <= ex_mem_addr_i;
      r_wr_data  <= ex_mem_wr_data_i;
      r_misalign <= misalign_in;
    end else if (ack_hit && !r_rw) begin
      r_wdata    <= ld_data;
    end
  end

  assign rdata_sel = (state_q == ST_WAIT_BUS) ? bus_rdata_i : dc_rdata_i;

  mem_lane_fmt u_lane_fmt (
    .width   (r_width),
    .rdtype  (r_rdtype),
    .addr_lo (r_addr[1:0]),
    .wr_data (r_wr_data),
    .rdata   (rdata_sel),
    .st_data (st_data),
    .st_strb (st_strb),
    .ld_data (ld_data)
  );

  // Request payload comes straight from the EX/MEM register, so it is stable
  // for the whole wait and never depends on the ack.
  assign dc_req_o    = (state_q == ST_WAIT_DC);
  assign bus_req_o   = (state_q == ST_WAIT_BUS);
  assign mem_rw_o    = in_req && r_rw;
  assign mem_addr_o  = in_req ? {r_addr[31:2], 2'b00} : 32'h0;
  assign mem_wdata_o = (in_req && r_rw) ? st_data : 32'h0;
  assign mem_wstrb_o = (in_req && r_rw) ? st_strb : 4'h0;

  assign mem_valid_o     = (state_q == ST_RESP);
  assign mem_reg_wdata_o = mem_valid_o ? r_wdata : 32'h0;
  assign mem_reg_waddr_o = mem_valid_o ? r_waddr : 5'h0;
  assign mem_reg_we_o    = mem_valid_o && r_we && !r_misalign;

`ifdef MEM_MISALIGN_TRAP_EN
  assign mem_misalign_o  = mem_valid_o && r_misalign;
`else
  assign mem_misalign_o  = 1'b0;
`endif

endmodule
